// File: rtl/stack_pkg.sv
// Shared constants and direction encoding for the path stack and the path-walker.
package stack_pkg;

   localparam int unsigned DIR_W       = 2;
   localparam int unsigned STACK_DEPTH = 256;

   typedef enum logic [1:0] {
      UP    = 2'b00,
      RIGHT = 2'b01,
      DOWN  = 2'b10,
      LEFT  = 2'b11
   } dir_e;

endpackage

// File: rtl/stack_mem.sv
// Stack storage: one synchronous write port and one asynchronous read port.
// The array has no reset; contents are qualified by the stack count.
module stack_mem #(
   parameter  int unsigned width  = 2,
   parameter  int unsigned depth  = 256,
   localparam int unsigned addr_w = $clog2(depth)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [addr_w-1:0] waddr,
   input  logic [width-1:0]  wdata,
   input  logic [addr_w-1:0] raddr,
   output logic [width-1:0]  rdata
);

   logic [width-1:0] mem [depth];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/param_stack.sv
// Parametrised LIFO with registered top-of-stack, pop result strobe,
// replace-top on simultaneous push+pop, synchronous clear and sticky error flags.
module param_stack
   import stack_pkg::*;
#(
   parameter  int unsigned direction_length = DIR_W,
   parameter  int unsigned size             = STACK_DEPTH,
   localparam int unsigned cnt_w            = $clog2(size + 1),
   localparam int unsigned addr_w           = $clog2(size)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        clear,
   input  logic                        push,
   input  logic                        pop,
   input  logic [direction_length-1:0] data_in,
   output logic [direction_length-1:0] data_out,
   output logic                        data_valid,
   output logic [direction_length-1:0] top,
   output logic                        empty,
   output logic                        full,
   output logic [cnt_w-1:0]            count,
   output logic                        overflow,
   output logic                        underflow
);

   logic [cnt_w-1:0]            count_nxt;
   logic [direction_length-1:0] top_nxt;
   logic [direction_length-1:0] data_out_nxt;
   logic                        data_valid_nxt;
   logic                        overflow_nxt;
   logic                        underflow_nxt;
   logic                        mem_we;
   logic [addr_w-1:0]           mem_waddr;
   logic [addr_w-1:0]           mem_raddr;
   logic [direction_length-1:0] mem_rdata;

   // Element below the current top, used to refill the top register on pop.
   assign mem_raddr = addr_w'(count - cnt_w'(2));

   stack_mem #(
      .width (direction_length),
      .depth (size)
   ) u_mem (
      .clk   (clk),
      .we    (mem_we),
      .waddr (mem_waddr),
      .wdata (data_in),
      .raddr (mem_raddr),
      .rdata (mem_rdata)
   );

   // Next-state decode: clear beats push/pop; pop is resolved before push.
   always_comb begin
      count_nxt      = count;
      top_nxt        = top;
      data_out_nxt   = data_out;
      data_valid_nxt = 1'b0;
      overflow_nxt   = overflow;
      underflow_nxt  = underflow;
      mem_we         = 1'b0;
      mem_waddr      = '0;

      if (clear) begin
         count_nxt     = '0;
         top_nxt       = '0;
         overflow_nxt  = 1'b0;
         underflow_nxt = 1'b0;
      end else if (push && pop) begin
         if (empty) begin
            mem_we        = 1'b1;
            mem_waddr     = '0;
            count_nxt     = cnt_w'(1);
            top_nxt       = data_in;
            underflow_nxt = 1'b1;
         end else begin
            data_out_nxt   = top;
            data_valid_nxt = 1'b1;
            mem_we         = 1'b1;
            mem_waddr      = addr_w'(count - cnt_w'(1));
            top_nxt        = data_in;
         end
      end else if (push) begin
         if (full) begin
            overflow_nxt = 1'b1;
         end else begin
            mem_we    = 1'b1;
            mem_waddr = addr_w'(count);
            count_nxt = count + cnt_w'(1);
            top_nxt   = data_in;
         end
      end else if (pop) begin
         if (empty) begin
            underflow_nxt = 1'b1;
         end else begin
            data_out_nxt   = top;
            data_valid_nxt = 1'b1;
            count_nxt      = count - cnt_w'(1);
            top_nxt        = (count >= cnt_w'(2)) ? mem_rdata : '0;
         end
      end
   end

   // empty/full are registered alongside count so no input reaches an output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count      <= '0;
         top        <= '0;
         data_out   <= '0;
         data_valid <= 1'b0;
         overflow   <= 1'b0;
         underflow  <= 1'b0;
         empty      <= 1'b1;
         full       <= 1'b0;
      end else begin
         count      <= count_nxt;
         top        <= top_nxt;
         data_out   <= data_out_nxt;
         data_valid <= data_valid_nxt;
         overflow   <= overflow_nxt;
         underflow  <= underflow_nxt;
         empty      <= (count_nxt == '0);
         full       <= (count_nxt == cnt_w'(size));
      end
   end

endmodule

// File: tb/tb_param_stack.sv
// Randomised and directed bench for param_stack against a queue-based LIFO model.
module tb_param_stack;

   localparam int unsigned W   = 2;
   localparam int unsigned D   = 4;
   localparam int unsigned CW  = 3;
   localparam int unsigned DD  = 256;
   localparam int unsigned CWD = 9;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // small instance (size 4)
   logic          clr_s = 1'b0, push_s = 1'b0, pop_s = 1'b0;
   logic [W-1:0]  din_s = '0;
   logic [W-1:0]  dout_s, top_s;
   logic          dv_s, empty_s, full_s, ovf_s, unf_s;
   logic [CW-1:0] cnt_s;

   // default instance (size 256)
   logic           clr_d = 1'b0, push_d = 1'b0, pop_d = 1'b0;
   logic [W-1:0]   din_d = '0;
   logic [W-1:0]   dout_d, top_d;
   logic           dv_d, empty_d, full_d, ovf_d, unf_d;
   logic [CWD-1:0] cnt_d;

   param_stack #(.direction_length(W), .size(D)) dut_s (
      .clk(clk), .rst_n(rst_n), .clear(clr_s), .push(push_s), .pop(pop_s),
      .data_in(din_s), .data_out(dout_s), .data_valid(dv_s), .top(top_s),
      .empty(empty_s), .full(full_s), .count(cnt_s),
      .overflow(ovf_s), .underflow(unf_s)
   );

   param_stack dut_d (
      .clk(clk), .rst_n(rst_n), .clear(clr_d), .push(push_d), .pop(pop_d),
      .data_in(din_d), .data_out(dout_d), .data_valid(dv_d), .top(top_d),
      .empty(empty_d), .full(full_d), .count(cnt_d),
      .overflow(ovf_d), .underflow(unf_d)
   );

   // reference model of the small instance
   logic [W-1:0] q[$];
   logic [W-1:0] m_dout;
   logic         m_dv, m_ovf, m_unf;

   int n_tests = 0;
   int n_fail  = 0;

   function automatic logic [11:0] obs_s();
      return {cnt_s, top_s, empty_s, full_s, dout_s, dv_s, ovf_s, unf_s};
   endfunction

   function automatic logic [11:0] exp_s();
      logic [W-1:0] t;
      t = (q.size() > 0) ? q[$] : 2'b00;
      return {CW'(q.size()), t, q.size() == 0, q.size() == D, m_dout, m_dv, m_ovf, m_unf};
   endfunction

   task automatic model_reset();
      q.delete();
      m_dout = '0; m_dv = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
   endtask

   // LIFO semantics: pop is taken first, then push into whatever room remains
   task automatic model_apply(input logic pu, input logic po, input logic cl, input logic [W-1:0] din);
      m_dv = 1'b0;
      if (cl) begin
         q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
      end else begin
         if (po) begin
            if (q.size() == 0) m_unf = 1'b1;
            else begin m_dout = q.pop_back(); m_dv = 1'b1; end
         end
         if (pu) begin
            if (q.size() >= D) m_ovf = 1'b1;
            else q.push_back(din);
         end
      end
   endtask

   task automatic step_s(input logic pu, input logic po, input logic cl, input logic [W-1:0] din);
      @(negedge clk);
      push_s = pu; pop_s = po; clr_s = cl; din_s = din;
      @(posedge clk);
      model_apply(pu, po, cl, din);
      #1;
   endtask

   task automatic test_reset();
      model_reset();
      n_tests++;
      if (obs_s() !== exp_s()) begin
         n_fail++; $display("FAIL reset_state got=%h want=%h", obs_s(), exp_s());
      end
      n_tests++;
      if (empty_d !== 1'b1 || cnt_d !== '0 || top_d !== '0) begin
         n_fail++; $display("FAIL reset_default got empty=%b count=%0d top=%b want 1 0 00", empty_d, cnt_d, top_d);
      end
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_push_pop();
      logic [W-1:0] vals [3] = '{2'b01, 2'b10, 2'b11};
      foreach (vals[i]) begin
         step_s(1'b1, 1'b0, 1'b0, vals[i]);
         n_tests++;
         if (obs_s() !== exp_s()) begin
            n_fail++; $display("FAIL push_%0d got=%h want=%h", i, obs_s(), exp_s());
         end
      end
      n_tests++;
      if (cnt_s !== 3'd3 || top_s !== 2'b11 || empty_s !== 1'b0 || full_s !== 1'b0) begin
         n_fail++; $display("FAIL push3_state got count=%0d top=%b empty=%b full=%b want 3 11 0 0", cnt_s, top_s, empty_s, full_s);
      end
      for (int i = 0; i < 3; i++) begin
         step_s(1'b0, 1'b1, 1'b0, 2'b00);
         n_tests++;
         if (dout_s !== vals[2-i] || dv_s !== 1'b1) begin
            n_fail++; $display("FAIL pop_%0d got dout=%b dv=%b want %b 1", i, dout_s, dv_s, vals[2-i]);
         end
      end
      step_s(1'b0, 1'b0, 1'b0, 2'b00);
      n_tests++;
      if (obs_s() !== exp_s() || empty_s !== 1'b1 || top_s !== 2'b00) begin
         n_fail++; $display("FAIL pop_drain got=%h want=%h", obs_s(), exp_s());
      end
   endtask

   task automatic test_overflow();
      step_s(1'b0, 1'b0, 1'b1, 2'b00);
      for (int i = 0; i < 4; i++) step_s(1'b1, 1'b0, 1'b0, W'(i));
      n_tests++;
      if (full_s !== 1'b1 || cnt_s !== 3'd4) begin
         n_fail++; $display("FAIL full_state got full=%b count=%0d want 1 4", full_s, cnt_s);
      end
      step_s(1'b1, 1'b0, 1'b0, 2'b01);
      n_tests++;
      if (obs_s() !== exp_s() || ovf_s !== 1'b1 || top_s !== 2'b11) begin
         n_fail++; $display("FAIL overflow got=%h want=%h", obs_s(), exp_s());
      end
      step_s(1'b0, 1'b1, 1'b0, 2'b00);
      n_tests++;
      if (obs_s() !== exp_s() || dout_s !== 2'b11 || ovf_s !== 1'b1) begin
         n_fail++; $display("FAIL pop_after_ovf got=%h want=%h", obs_s(), exp_s());
      end
   endtask

   task automatic test_underflow();
      step_s(1'b0, 1'b0, 1'b1, 2'b00);
      step_s(1'b0, 1'b1, 1'b0, 2'b00);
      n_tests++;
      if (obs_s() !== exp_s() || unf_s !== 1'b1 || dv_s !== 1'b0) begin
         n_fail++; $display("FAIL underflow got=%h want=%h", obs_s(), exp_s());
      end
      step_s(1'b1, 1'b1, 1'b0, 2'b10);
      n_tests++;
      if (obs_s() !== exp_s() || cnt_s !== 3'd1 || top_s !== 2'b10 || dv_s !== 1'b0) begin
         n_fail++; $display("FAIL pushpop_empty got=%h want=%h", obs_s(), exp_s());
      end
   endtask

   task automatic test_replace_top();
      step_s(1'b0, 1'b0, 1'b1, 2'b00);
      step_s(1'b1, 1'b0, 1'b0, 2'b01);
      step_s(1'b1, 1'b0, 1'b0, 2'b10);
      step_s(1'b1, 1'b1, 1'b0, 2'b11);
      n_tests++;
      if (obs_s() !== exp_s() || dout_s !== 2'b10 || dv_s !== 1'b1 || cnt_s !== 3'd2 || top_s !== 2'b11) begin
         n_fail++; $display("FAIL replace_top got=%h want=%h", obs_s(), exp_s());
      end
      step_s(1'b0, 1'b1, 1'b0, 2'b00);
      n_tests++;
      if (dout_s !== 2'b11 || dv_s !== 1'b1) begin
         n_fail++; $display("FAIL replace_pop1 got dout=%b dv=%b want 11 1", dout_s, dv_s);
      end
      step_s(1'b0, 1'b1, 1'b0, 2'b00);
      n_tests++;
      if (obs_s() !== exp_s() || dout_s !== 2'b01) begin
         n_fail++; $display("FAIL replace_pop2 got=%h want=%h", obs_s(), exp_s());
      end
   endtask

   task automatic test_clear();
      step_s(1'b0, 1'b0, 1'b1, 2'b00);
      step_s(1'b0, 1'b1, 1'b0, 2'b00);
      for (int i = 0; i < 5; i++) step_s(1'b1, 1'b0, 1'b0, 2'b10);
      step_s(1'b0, 1'b1, 1'b0, 2'b00);
      n_tests++;
      if (cnt_s !== 3'd3 || ovf_s !== 1'b1 || unf_s !== 1'b1) begin
         n_fail++; $display("FAIL pre_clear got count=%0d ovf=%b unf=%b want 3 1 1", cnt_s, ovf_s, unf_s);
      end
      step_s(1'b1, 1'b0, 1'b1, 2'b11);
      n_tests++;
      if (obs_s() !== exp_s() || cnt_s !== 3'd0 || empty_s !== 1'b1 || ovf_s !== 1'b0 || unf_s !== 1'b0) begin
         n_fail++; $display("FAIL clear got=%h want=%h", obs_s(), exp_s());
      end
   endtask

   task automatic test_reset_mid();
      step_s(1'b1, 1'b0, 1'b0, 2'b01);
      step_s(1'b1, 1'b0, 1'b0, 2'b10);
      step_s(1'b1, 1'b1, 1'b0, 2'b01);
      @(negedge clk);
      push_s = 1'b1; pop_s = 1'b0; din_s = 2'b11;
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      n_tests++;
      if (obs_s() !== exp_s()) begin
         n_fail++; $display("FAIL async_reset got=%h want=%h", obs_s(), exp_s());
      end
      @(negedge clk);
      push_s = 1'b0;
      rst_n = 1'b1;
      step_s(1'b1, 1'b0, 1'b0, 2'b01);
      n_tests++;
      if (obs_s() !== exp_s() || cnt_s !== 3'd1 || top_s !== 2'b01) begin
         n_fail++; $display("FAIL post_reset_push got=%h want=%h", obs_s(), exp_s());
      end
   endtask

   task automatic test_random();
      int errs = 0;
      logic pu, po, cl;
      logic [W-1:0] din;
      for (int i = 0; i < 400; i++) begin
         pu  = 1'($urandom_range(0, 1));
         po  = 1'($urandom_range(0, 1));
         cl  = ($urandom_range(0, 39) == 0);
         din = W'($urandom);
         step_s(pu, po, cl, din);
         n_tests++;
         if (obs_s() !== exp_s()) begin
            n_fail++;
            if (errs < 10) $display("FAIL random_%0d got=%h want=%h", i, obs_s(), exp_s());
            errs++;
         end
      end
   endtask

   task automatic test_default_depth();
      logic [W-1:0] ref_q[$];
      int errs = 0;
      for (int i = 0; i < DD; i++) begin
         @(negedge clk);
         push_d = 1'b1; din_d = (i % 2 == 0) ? 2'b01 : 2'b10;
         ref_q.push_back(din_d);
      end
      @(negedge clk); push_d = 1'b0;
      n_tests++;
      if (full_d !== 1'b1 || cnt_d !== 9'd256 || top_d !== 2'b10) begin
         n_fail++; $display("FAIL deep_full got full=%b count=%0d top=%b want 1 256 10", full_d, cnt_d, top_d);
      end
      for (int i = 0; i < DD; i++) begin
         logic [W-1:0] want;
         @(negedge clk); pop_d = 1'b1;
         @(posedge clk); #1;
         want = ref_q.pop_back();
         n_tests++;
         if (dout_d !== want || dv_d !== 1'b1) begin
            n_fail++;
            if (errs < 10) $display("FAIL deep_pop_%0d got dout=%b dv=%b want %b 1", i, dout_d, dv_d, want);
            errs++;
         end
      end
      @(negedge clk); pop_d = 1'b0;
      n_tests++;
      if (empty_d !== 1'b1 || cnt_d !== '0 || ovf_d !== 1'b0 || unf_d !== 1'b0 || top_d !== 2'b00) begin
         n_fail++; $display("FAIL deep_end got empty=%b count=%0d ovf=%b unf=%b top=%b want 1 0 0 0 00",
                            empty_d, cnt_d, ovf_d, unf_d, top_d);
      end
   endtask

   initial begin
      #12;
      test_reset();
      test_push_pop();
      test_overflow();
      test_underflow();
      test_replace_top();
      test_clear();
      test_reset_mid();
      test_random();
      test_default_depth();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/param_stack.md
Name: param_stack

Overview:
- Parametrised LIFO for the direction/back-tracking path.
- Successor to the basic push/pop stack.
- Adds full flag, occupancy count, top-of-stack peek, a registered pop result with a valid strobe, and simultaneous push+pop (replace-top).
- Adds synchronous clear and sticky overflow/underflow error flags.

Parameters:
- direction_length, 2, element width in bits
- size, 256, depth in elements; must be >= 2
- cnt_w (localparam), $clog2(size+1), width of count

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous flush; highest priority after reset
- push  in  1  push request
- pop  in  1  pop request
- data_in  in  direction_length  element to push
- data_out  out  direction_length  element removed by the last accepted pop
- data_valid  out  1  one-cycle strobe: data_out updated this cycle
- top  out  direction_length  current top-of-stack (peek); 0 when empty
- empty  out  1  count == 0
- full  out  1  count == size
- count  out  cnt_w  number of stored elements
- overflow  out  1  sticky: a push was dropped
- underflow  out  1  sticky: a pop was refused

Behaviour:
- Reset (rst_n low, async): count=0, data_out=0, data_valid=0, top=0, overflow=0, underflow=0, empty=1, full=0. Memory contents are don't-care.
- All state updates on the rising clk edge. empty, full and top are derived from registered state: no combinational path from push/pop/data_in to any output.
- Internal sp = count. The element at index count-1 is top. top is held in a dedicated register kept coherent with memory.
- clear=1: count<=0, top<=0, overflow<=0, underflow<=0, data_valid<=0. push/pop ignored that cycle.
- Priority: rst_n > clear > push/pop.
- Default each cycle: data_valid<=0.
- push only, !full:
  - mem[count]<=data_in; count<=count+1; top<=data_in.
- push only, full:
  - Push dropped; overflow<=1; no other change.
- pop only, !empty:
  - data_out<=top; data_valid<=1; count<=count-1.
  - top<=mem[count-2] if count>=2, else 0.
- pop only, empty:
  - Refused; underflow<=1; data_out holds; data_valid stays 0.
- push and pop, !empty (includes full):
  - Replace-top: data_out<=top; data_valid<=1; mem[count-1]<=data_in; top<=data_in; count unchanged; no overflow.
- push and pop, empty:
  - Push accepted as a push-only (count<=1, top<=data_in); pop refused, underflow<=1, no data_valid.
- Latency:
  - Pushed value is visible on top the next cycle.
  - Popped value is on data_out with data_valid the cycle after the pop edge.
- Flags are sticky until clear or reset.
- count never exceeds size and never wraps below 0.
- Reset mid-operation: all outputs return to reset values immediately (async); a pending push/pop is lost.

Decomposition:
- Package stack_pkg:
  - Default width/depth constants (DIR_W=2, STACK_DEPTH=256).
  - Direction encoding enum (UP=2'b00, RIGHT=2'b01, DOWN=2'b10, LEFT=2'b11), shared with the path-walker.
- Sub-module stack_mem:
  - size x direction_length storage, one synchronous write port, one asynchronous read port (address count-2 for top refill). No reset on the array.
- param_stack holds the pointer/count, top register, flags and control.

Test Plan (bench uses direction_length=2, size=4 unless noted):
- Reset, then push 01,10,11 → count=3, top=11, empty=0, full=0. Then pop x3 → data_out 11,10,01, each with a data_valid pulse; final empty=1, top=00.
- Push 00,01,10,11 → full=1, count=4. Push 01 again → overflow=1, count=4, top=11. Pop → data_out=11, overflow still 1.
- From empty, pop → underflow=1, data_valid=0, data_out unchanged. Then push+pop same cycle with data_in=10 → count=1, top=10, no data_valid.
- Stack holds 01,10 (top=10); push+pop with data_in=11 → data_out=10, data_valid=1, count=2, top=11. Then pop x2 → 11, 01.
- With count=3, overflow=1 and underflow=1, assert clear → count=0, empty=1, both flags 0. A push in the clear cycle is ignored.
- Mid-stream: push 11 and drop rst_n between edges → outputs at reset values before the next edge. After release, push 01 → count=1, top=01.
- Default params (2, 256): push 256 alternating 01/10 → full=1. Pop 256 → exact LIFO order, no flags set.
